// File: rtl/vec_mem_port_if.sv
// Vector core memory-port bus: request/write channel and load-data response.
interface vec_mem_port_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  mem_port_req;
    logic                  mem_port_wr_valid;
    logic [ADDR_WIDTH-1:0] mem_port_addr;
    logic [DATA_WIDTH-1:0] mem_port_wr_data;
    logic                  mem_port_ready;
    logic [DATA_WIDTH-1:0] mem_port_rd_data;
    logic                  mem_port_rd_valid;

    modport master (
        output mem_port_req,
        output mem_port_wr_valid,
        output mem_port_addr,
        output mem_port_wr_data,
        input  mem_port_ready,
        input  mem_port_rd_data,
        input  mem_port_rd_valid
    );

    modport slave (
        input  mem_port_req,
        input  mem_port_wr_valid,
        input  mem_port_addr,
        input  mem_port_wr_data,
        output mem_port_ready,
        output mem_port_rd_data,
        output mem_port_rd_valid
    );
endinterface

// File: rtl/vec_mem_port.sv
// Scratchpad memory slave for the vector core memory port, with a 32-bit
// host preload port and a sticky address-error flag.
module vec_mem_port #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vec_mem_port_if.slave         bus,
    input  logic                  host_wr_en,
    input  logic [DEPTH_LOG2-1:0] host_idx,
    input  logic                  host_hi,
    input  logic [31:0]           host_wdata,
    output logic                  host_wr_ack,
    output logic                  addr_err,
    input  logic                  addr_err_clr
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned HOST_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_LSB = 3;
    localparam int unsigned IDX_MSB = DEPTH_LOG2 + 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  addr_ok_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  err_new_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // Address decode and request acceptance
    assign idx_c     = bus.mem_port_addr[IDX_MSB:IDX_LSB];
    assign addr_ok_c = (bus.mem_port_addr[2:0] == 3'b000) &&
                       (bus.mem_port_addr[ADDR_WIDTH-1:IDX_MSB+1] == '0);
    assign rd_acc_c  = bus.mem_port_req && ready_q;
    assign wr_acc_c  = bus.mem_port_wr_valid && ready_q;
    assign err_new_c = (rd_acc_c || wr_acc_c) && !addr_ok_c;

    // Read word at accept: bad address reads zero, same-cycle core write wins
    always_comb begin
        rd_word_c = '0;
        if (addr_ok_c) begin
            rd_word_c = wr_acc_c ? bus.mem_port_wr_data : mem[idx_c];
        end
    end

    // Word store; core write has priority, host write is deferred behind it
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            if (addr_ok_c) begin
                mem[idx_c] <= bus.mem_port_wr_data;
            end
        end else if (host_wr_en) begin
            if (host_hi) begin
                mem[host_idx][HOST_W +: HOST_W] <= host_wdata;
            end else begin
                mem[host_idx][0 +: HOST_W] <= host_wdata;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_buf_q   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_buf_q   <= rd_buf_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // Next-state: read latency sequencing, host ack and sticky error flag
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_buf_d   = rd_buf_q;
        ack_d      = host_wr_en && !wr_acc_c;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (rd_acc_c) begin
                    if (READ_LAT == 1) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rd_word_c;
                    end else begin
                        state_d  = RD_WAIT;
                        cnt_d    = CNT_W'(READ_LAT - 2);
                        ready_d  = 1'b0;
                        rd_buf_d = rd_word_c;
                    end
                end
            end
            RD_WAIT: begin
                ready_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    ready_d    = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_buf_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_new_c) begin
            err_d = 1'b1;
        end else if (addr_err_clr) begin
            err_d = 1'b0;
        end
    end

    assign bus.mem_port_ready    = ready_q;
    assign bus.mem_port_rd_valid = rd_valid_q;
    assign bus.mem_port_rd_data  = rd_data_q;
    assign host_wr_ack           = ack_q;
    assign addr_err              = err_q;

endmodule

// File: tb/tb_vec_mem_port.sv
// Self-checking bench for vec_mem_port against a word-array reference model.
module tb_vec_mem_port;
    localparam int unsigned READ_LAT = 2;
    localparam int unsigned WORDS    = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_wr_en = 1'b0;
    logic [7:0]  host_idx = '0;
    logic        host_hi = 1'b0;
    logic [31:0] host_wdata = '0;
    logic        host_wr_ack;
    logic        addr_err;
    logic        addr_err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem_m [WORDS];
    bit          known_lo [WORDS];
    bit          known_hi [WORDS];

    always #5 clk = ~clk;

    vec_mem_port_if bus ();

    vec_mem_port #(.READ_LAT(READ_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .host_wr_en   (host_wr_en),
        .host_idx     (host_idx),
        .host_hi      (host_hi),
        .host_wdata   (host_wdata),
        .host_wr_ack  (host_wr_ack),
        .addr_err     (addr_err),
        .addr_err_clr (addr_err_clr)
    );

    // Reference model: byte address legality and word index by plain arithmetic
    function automatic bit a_valid(input longint unsigned a);
        return (a % 8 == 0) && (a < WORDS * 8);
    endfunction

    function automatic int a_idx(input longint unsigned a);
        return int'((a / 8) % WORDS);
    endfunction

    function automatic void m_core_write(input longint unsigned a, input logic [63:0] d);
        if (a_valid(a)) begin
            mem_m[a_idx(a)] = d;
            known_lo[a_idx(a)] = 1'b1;
            known_hi[a_idx(a)] = 1'b1;
        end
    endfunction

    function automatic void m_host_write(input int i, input bit hi, input logic [31:0] d);
        if (hi) begin
            mem_m[i][63:32] = d;
            known_hi[i] = 1'b1;
        end else begin
            mem_m[i][31:0] = d;
            known_lo[i] = 1'b1;
        end
    endfunction

    // Drive one read (optionally with a same-cycle write); return data, latency, ready behaviour
    task automatic do_read(input logic [31:0] a, input bit with_wr, input logic [63:0] wd,
                           output logic [63:0] d, output int lat, output bit ready_ok);
        bus.mem_port_req      = 1'b1;
        bus.mem_port_addr     = a;
        bus.mem_port_wr_valid = with_wr;
        bus.mem_port_wr_data  = wd;
        @(negedge clk);
        bus.mem_port_req      = 1'b0;
        bus.mem_port_wr_valid = 1'b0;
        lat = 0;
        ready_ok = 1'b1;
        d = '0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_port_rd_valid === 1'b1) begin
                lat = k;
                d = bus.mem_port_rd_data;
                if (bus.mem_port_ready !== 1'b1) ready_ok = 1'b0;
                break;
            end
            if (bus.mem_port_ready !== 1'b0) ready_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d);
        bus.mem_port_wr_valid = 1'b1;
        bus.mem_port_addr     = a;
        bus.mem_port_wr_data  = d;
        @(negedge clk);
        bus.mem_port_wr_valid = 1'b0;
    endtask

    task automatic host_write(input int i, input bit hi, input logic [31:0] d, output int dly);
        host_wr_en = 1'b1;
        host_idx   = 8'(i);
        host_hi    = hi;
        host_wdata = d;
        dly = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (host_wr_ack === 1'b1) begin
                dly = k;
                break;
            end
        end
        host_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_port_req      = 1'b0;
        bus.mem_port_wr_valid = 1'b0;
        bus.mem_port_addr     = '0;
        bus.mem_port_wr_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_port_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.mem_port_ready); end
        checks++;
        if (bus.mem_port_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.mem_port_rd_valid); end
        checks++;
        if (bus.mem_port_rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.mem_port_rd_data); end
        checks++;
        if (host_wr_ack !== 1'b0 || addr_err !== 1'b0) begin
            errors++; $display("FAIL reset_ack_err: got ack=%b err=%b want 0/0", host_wr_ack, addr_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_port_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.mem_port_ready); end
    endtask

    task automatic test_write_read();
        logic [63:0] d;
        int lat;
        bit rok;
        do_write(32'h10, 64'h1122334455667788);
        m_core_write(32'h10, 64'h1122334455667788);
        do_read(32'h10, 1'b0, '0, d, lat, rok);
        checks++;
        if (lat != READ_LAT) begin errors++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, READ_LAT); end
        checks++;
        if (d !== mem_m[2]) begin errors++; $display("FAIL wr_rd_data: got %h want %h", d, mem_m[2]); end
        checks++;
        if (!rok) begin errors++; $display("FAIL wr_rd_ready: got ready-profile bad want low-until-response"); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_port_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", bus.mem_port_rd_valid); end
        checks++;
        if (bus.mem_port_rd_data !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_data_hold: got %h want 1122334455667788", bus.mem_port_rd_data);
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [63:0] d;
        int lat;
        bit rok;
        do_read(32'h08, 1'b1, 64'hA5A5A5A5A5A5A5A5, d, lat, rok);
        m_core_write(32'h08, 64'hA5A5A5A5A5A5A5A5);
        checks++;
        if (d !== mem_m[1] || lat != READ_LAT) begin
            errors++; $display("FAIL rw_write_first: got %h lat %0d want %h lat %0d", d, lat, mem_m[1], READ_LAT);
        end
    endtask

    task automatic test_addr_err();
        logic [63:0] d;
        int lat;
        bit rok;
        logic [31:0] bad [2];
        bad[0] = 32'h0C;
        bad[1] = 32'h800;
        for (int i = 0; i < 2; i++) begin
            do_read(bad[i], 1'b0, '0, d, lat, rok);
            checks++;
            if (d !== 64'h0 || lat != READ_LAT || addr_err !== 1'b1) begin
                errors++; $display("FAIL bad_read_%0d: got data %h lat %0d err %b want 0 lat %0d err 1", i, d, lat, addr_err, READ_LAT);
            end
        end
        addr_err_clr = 1'b1;
        @(negedge clk);
        addr_err_clr = 1'b0;
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", addr_err); end
        // Error and clear in the same cycle: error wins
        addr_err_clr = 1'b1;
        do_write(32'h810, 64'hFFFF_FFFF_FFFF_FFFF);
        addr_err_clr = 1'b0;
        checks++;
        if (addr_err !== 1'b1) begin errors++; $display("FAIL err_beats_clear: got %b want 1", addr_err); end
        do_write(32'h11, 64'hEEEE_EEEE_EEEE_EEEE);
        do_read(32'h10, 1'b0, '0, d, lat, rok);
        checks++;
        if (d !== mem_m[2]) begin errors++; $display("FAIL bad_write_dropped: got %h want %h", d, mem_m[2]); end
        addr_err_clr = 1'b1;
        @(negedge clk);
        addr_err_clr = 1'b0;
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear2: got %b want 0", addr_err); end
    endtask

    task automatic test_host_write();
        logic [63:0] d;
        int lat;
        int dly;
        bit rok;
        host_write(3, 1'b0, 32'hDEADBEEF, dly);
        m_host_write(3, 1'b0, 32'hDEADBEEF);
        checks++;
        if (dly != 1) begin errors++; $display("FAIL host_ack_lo: got delay %0d want 1", dly); end
        host_write(3, 1'b1, 32'hCAFEF00D, dly);
        m_host_write(3, 1'b1, 32'hCAFEF00D);
        checks++;
        if (dly != 1) begin errors++; $display("FAIL host_ack_hi: got delay %0d want 1", dly); end
        @(negedge clk);
        do_read(32'h18, 1'b0, '0, d, lat, rok);
        checks++;
        if (d !== 64'hCAFEF00DDEADBEEF || d !== mem_m[3]) begin
            errors++; $display("FAIL host_read: got %h want cafef00ddeadbeef", d);
        end
        // Host write racing a core read of the same word: read sees the old value
        host_wr_en = 1'b1;
        host_idx   = 8'd3;
        host_hi    = 1'b0;
        host_wdata = 32'h0BADF00D;
        do_read(32'h18, 1'b0, '0, d, lat, rok);
        host_wr_en = 1'b0;
        checks++;
        if (d !== mem_m[3]) begin errors++; $display("FAIL host_read_race: got %h want %h", d, mem_m[3]); end
        m_host_write(3, 1'b0, 32'h0BADF00D);
        @(negedge clk);
        do_read(32'h18, 1'b0, '0, d, lat, rok);
        checks++;
        if (d !== mem_m[3]) begin errors++; $display("FAIL host_after_race: got %h want %h", d, mem_m[3]); end
    endtask

    task automatic test_host_collision();
        logic [63:0] d;
        int lat;
        bit rok;
        bus.mem_port_wr_valid = 1'b1;
        bus.mem_port_addr     = 32'h28;
        bus.mem_port_wr_data  = 64'h0123456789ABCDEF;
        host_wr_en = 1'b1;
        host_idx   = 8'd5;
        host_hi    = 1'b1;
        host_wdata = 32'h55AA55AA;
        @(negedge clk);
        bus.mem_port_wr_valid = 1'b0;
        checks++;
        if (host_wr_ack !== 1'b0) begin errors++; $display("FAIL collide_defer: got ack %b want 0", host_wr_ack); end
        @(negedge clk);
        host_wr_en = 1'b0;
        checks++;
        if (host_wr_ack !== 1'b1) begin errors++; $display("FAIL collide_ack: got ack %b want 1", host_wr_ack); end
        m_core_write(32'h28, 64'h0123456789ABCDEF);
        m_host_write(5, 1'b1, 32'h55AA55AA);
        do_read(32'h28, 1'b0, '0, d, lat, rok);
        checks++;
        if (d !== mem_m[5]) begin errors++; $display("FAIL collide_data: got %h want %h", d, mem_m[5]); end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [63:0] wd;
        logic [31:0] a;
        int lat;
        int dly;
        bit rok;
        int i;
        for (int n = 0; n < 16; n++) begin
            wd = {$urandom, $urandom};
            do_write(32'(n * 8), wd);
            m_core_write(longint'(n * 8), wd);
        end
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 32'($urandom_range(0, 15) * 8);
                    wd = {$urandom, $urandom};
                    do_write(a, wd);
                    m_core_write(a, wd);
                end
                1: begin
                    i = $urandom_range(0, 15);
                    do_read(32'(i * 8), 1'b0, '0, d, lat, rok);
                    if (known_lo[i] && known_hi[i]) begin
                        checks++;
                        if (d !== mem_m[i] || lat != READ_LAT || !rok) begin
                            errors++; $display("FAIL rand_read idx %0d: got %h lat %0d want %h lat %0d", i, d, lat, mem_m[i], READ_LAT);
                        end
                    end
                end
                2: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2047) * 8 + $urandom_range(1, 7))
                                                    : 32'(32'h800 + $urandom_range(0, 100000) * 8);
                    do_read(a, 1'b0, '0, d, lat, rok);
                    checks++;
                    if (a_valid(a) || d !== 64'h0 || lat != READ_LAT || addr_err !== 1'b1) begin
                        errors++; $display("FAIL rand_bad addr %h: got %h lat %0d err %b want 0 lat %0d err 1", a, d, lat, addr_err, READ_LAT);
                    end
                    addr_err_clr = 1'b1;
                    @(negedge clk);
                    addr_err_clr = 1'b0;
                end
                default: begin
                    i = $urandom_range(0, 15);
                    wd[31:0] = $urandom;
                    wd[32] = 1'($urandom_range(0, 1));
                    host_write(i, wd[32], wd[31:0], dly);
                    m_host_write(i, wd[32], wd[31:0]);
                    checks++;
                    if (dly != 1) begin errors++; $display("FAIL rand_host idx %0d: got delay %0d want 1", i, dly); end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] d;
        int lat;
        bit rok;
        bit seen;
        bus.mem_port_req  = 1'b1;
        bus.mem_port_addr = 32'h10;
        @(negedge clk);
        bus.mem_port_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_port_ready !== 1'b0 || bus.mem_port_rd_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got ready %b valid %b want 0/0", bus.mem_port_ready, bus.mem_port_rd_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_port_rd_valid === 1'b1) seen = 1'b1;
            if (k == 0) begin
                checks++;
                if (bus.mem_port_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.mem_port_ready); end
            end
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_valid: got rd_valid 1 want none"); end
        do_read(32'h10, 1'b0, '0, d, lat, rok);
        if (known_lo[2] && known_hi[2]) begin
            checks++;
            if (d !== mem_m[2] || lat != READ_LAT) begin
                errors++; $display("FAIL midrst_retained: got %h lat %0d want %h lat %0d", d, lat, mem_m[2], READ_LAT);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_rw_same_cycle();
        test_addr_err();
        test_host_write();
        test_host_collision();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
